// File: rtl/irrigation_bcd_down_timer_pkg.sv
// Shared types and helpers for the irrigation BCD down-timer.
package irrigation_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Force a possibly-invalid BCD nibble into the 0..9 range.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/irrigation_bcd_down_timer_digit.sv
// One BCD digit of the down-counter: load, or decrement with borrow ripple.
module bcd_down_digit
  import irrigation_pkg::*;
#(
  parameter logic [BCD_W-1:0] RESET_DIGIT = 4'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec_en,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out,
  output logic             is_zero
);

  assign is_zero    = (digit == BCD_W'(0));
  assign borrow_out = borrow_in & is_zero;

  // Digit register: reset beats load beats decrement; 0 with borrow wraps to 9.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= RESET_DIGIT;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec_en && borrow_in) begin
      digit <= is_zero ? BCD_MAX : (digit - BCD_W'(1));
    end
  end

endmodule

// File: rtl/irrigation_bcd_down_timer.sv
// Multi-digit BCD run-time down-counter for valve control.
// Optional build macro IRRIGATION_TIMER_PAUSE_EN adds a pause input that
// freezes counting while in RUN.
module irrigation_bcd_down_timer
  import irrigation_pkg::*;
#(
  parameter int unsigned             DIGITS      = 2,
  parameter logic [4*DIGITS-1:0]     RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  tick,
  input  logic                  auto_reload,
`ifdef IRRIGATION_TIMER_PAUSE_EN
  input  logic                  pause,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);

  localparam int unsigned CW = BCD_W * DIGITS;

  state_t          state_q, state_d;
  logic            done_d;
  logic [CW-1:0]   preset_q;
  logic [CW-1:0]   preset_clamped;
  logic [CW-1:0]   load_val;
  logic            load_en;
  logic            dec_en;
  logic            tick_en;
  logic [DIGITS:0] borrow;
  logic [DIGITS-1:0] zero_vec;
  logic            count_is_zero;
  logic            count_is_one;

`ifdef IRRIGATION_TIMER_PAUSE_EN
  assign tick_en = tick & ~pause;
`else
  assign tick_en = tick;
`endif

  // Clamp each incoming preset digit to a valid BCD value.
  always_comb begin
    preset_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      preset_clamped[BCD_W*i +: BCD_W] = bcd_clamp(preset[BCD_W*i +: BCD_W]);
    end
  end

  // A borrow that ripples out of the top digit means every digit is zero.
  assign borrow[0]     = 1'b1;
  assign count_is_zero = borrow[DIGITS];
  assign count_is_one  = (count[BCD_W-1:0] == BCD_W'(1)) &&
                         ((zero_vec | DIGITS'(1)) == {DIGITS{1'b1}});

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_down_digit #(
      .RESET_DIGIT(RESET_VALUE[BCD_W*i +: BCD_W])
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .load      (load_en),
      .load_digit(load_val[BCD_W*i +: BCD_W]),
      .dec_en    (dec_en),
      .borrow_in (borrow[i]),
      .digit     (count[BCD_W*i +: BCD_W]),
      .borrow_out(borrow[i+1]),
      .is_zero   (zero_vec[i])
    );
  end

  // Preset register keeps the clamped run time for auto-reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_q <= '0;
    end else if (load) begin
      preset_q <= preset_clamped;
    end
  end

  // State and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Next state, expiry pulse and digit load/decrement control.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_val = preset_clamped;
    dec_en   = 1'b0;
    if (load) begin
      load_en = 1'b1;
      if (preset_clamped == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && tick_en) begin
      if (count_is_zero) begin
        // Zero shown for one tick after an auto-reload expiry; restart now.
        load_en  = 1'b1;
        load_val = preset_q;
      end else begin
        dec_en = 1'b1;
        if (count_is_one) begin
          done_d = 1'b1;
          if (!auto_reload) begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: tb/tb_irrigation_bcd_down_timer.sv
// Directed table-driven bench for irrigation_bcd_down_timer (DIGITS=2, RESET_VALUE=0).
module tb_irrigation_bcd_down_timer;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned CW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [CW-1:0] preset;
  logic          tick;
  logic          auto_reload;
  logic [CW-1:0] count;
  logic          running;
  logic          done;
`ifdef IRRIGATION_TIMER_PAUSE_EN
  logic          pause;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic          rst;
    logic          ld;
    logic [CW-1:0] pre;
    logic          tk;
    logic          ar;
    logic [CW-1:0] cnt;
    logic          run;
    logic          dn;
  } vec_t;

  vec_t vq[$];

  irrigation_bcd_down_timer #(
    .DIGITS     (DIGITS),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .preset     (preset),
    .tick       (tick),
    .auto_reload(auto_reload),
`ifdef IRRIGATION_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .count      (count),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic rst, input logic ld, input logic [CW-1:0] pre,
                              input logic tk, input logic ar,
                              input logic [CW-1:0] cnt, input logic run, input logic dn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.pre = pre; v.tk = tk; v.ar = ar;
    v.cnt = cnt; v.run = run; v.dn = dn;
    vq.push_back(v);
  endfunction

  function automatic logic [CW-1:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  // Apply inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic drive(input logic r, input logic ld, input logic [CW-1:0] p,
                       input logic tk, input logic ar);
    reset = r; load = ld; preset = p; tick = tk; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [CW-1:0] ec, input logic er, input logic ed);
    n_vec++;
    if (count !== ec || running !== er || done !== ed) begin
      n_err++;
      $display("FAIL %s: got count=%h running=%b done=%b, expected count=%h running=%b done=%b",
               nm, count, running, done, ec, er, ed);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; preset = '0; tick = 1'b0; auto_reload = 1'b0;
`ifdef IRRIGATION_TIMER_PAUSE_EN
    pause = 1'b0;
`endif

    // rst ld preset tick ar -> count run done
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);          // reset state
    add(0, 1, 8'h12, 0, 0, 8'h12, 1, 0);          // one-shot load 12
    for (int n = 11; n >= 1; n--) add(0, 0, 8'h00, 1, 0, to_bcd(n), 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);          // expiry
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);          // idle ignores ticks
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h10, 0, 0, 8'h10, 1, 0);          // cross-digit borrow
    add(0, 0, 8'h00, 1, 0, 8'h09, 1, 0);
    add(0, 1, 8'h03, 0, 1, 8'h03, 1, 0);          // auto-reload run
    add(0, 0, 8'h00, 1, 1, 8'h02, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h01, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h00, 1, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 1, 0);          // zero held between ticks
    add(0, 0, 8'h00, 1, 1, 8'h03, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h02, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h01, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h00, 1, 1);
    add(0, 0, 8'h00, 1, 1, 8'h03, 1, 0);
    add(0, 0, 8'h00, 0, 1, 8'h03, 1, 0);
    add(0, 1, 8'h3C, 0, 0, 8'h39, 1, 0);          // clamp LSD
    add(0, 1, 8'hFA, 0, 0, 8'h99, 1, 0);          // clamp both digits
    add(0, 0, 8'h00, 1, 0, 8'h98, 1, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0, 1);          // zero preset
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add(0, 1, 8'h05, 0, 0, 8'h05, 1, 0);          // load wins over tick
    add(0, 1, 8'h20, 1, 0, 8'h20, 1, 0);
    add(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);          // reset wins over tick
    add(1, 1, 8'h45, 1, 0, 8'h00, 0, 0);          // reset wins over load
    add(0, 1, 8'h02, 0, 0, 8'h02, 1, 0);          // auto_reload sampled at expiry
    add(0, 0, 8'h00, 1, 1, 8'h01, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
    add(0, 1, 8'h02, 0, 0, 8'h02, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h01, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h00, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h02, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h01, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ld, vq[i].pre, vq[i].tk, vq[i].ar);
      check($sformatf("vec%0d", i), vq[i].cnt, vq[i].run, vq[i].dn);
    end

    // Full 99-tick countdown against a decimal model.
    drive(0, 1, 8'h99, 0, 0);
    check("load99", 8'h99, 1'b1, 1'b0);
    for (int k = 1; k <= 99; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      check($sformatf("cd99_%0d", k), to_bcd(99 - k), (k < 99), (k == 99));
    end
    drive(0, 0, 8'h00, 1, 0);
    check("cd99_after", 8'h00, 1'b0, 1'b0);

`ifdef IRRIGATION_TIMER_PAUSE_EN
    drive(0, 1, 8'h07, 0, 0);
    check("pause_load", 8'h07, 1'b1, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      check($sformatf("paused_%0d", k), 8'h07, 1'b1, 1'b0);
    end
    pause = 1'b0;
    drive(0, 0, 8'h00, 1, 0);
    check("unpaused", 8'h06, 1'b1, 1'b0);
    pause = 1'b1;
    drive(0, 1, 8'h31, 1, 0);
    check("pause_load_acts", 8'h31, 1'b1, 1'b0);
    pause = 1'b0;
`endif

    drive(0, 0, 8'h00, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irrigation_bcd_down_timer.md
Name: irrigation_bcd_down_timer

Overview:
- Parametrised multi-digit BCD down-counter for sprinkler/valve run-time control.
- Generalises the fixed single-digit sprinkler counter:
  - digit count set by parameter
  - run-time preset loaded at run time
  - optional auto-reload (cyclic irrigation)
  - explicit run/done status
- Driven by a slow tick enable from the prescaler.
- Output feeds the valve driver and 7-segment display decoders.

Parameters:
- DIGITS, 2, number of BCD digits (1..4); count width = 4*DIGITS.
- RESET_VALUE, 0, BCD value loaded into count on reset (must be valid BCD).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, synchronous, active-high; clears to reset state.
- load, input, 1, one-cycle strobe; captures preset and starts a run.
- preset, input, 4*DIGITS, BCD run-time value; digit 0 is the LSD.
- tick, input, 1, count enable (one-cycle pulse per time unit).
- auto_reload, input, 1, 1 = reload preset on expiry and keep running; 0 = one-shot.
- count, output, 4*DIGITS, current BCD value; digit i = count[4i+3:4i].
- running, output, 1, high while in RUN (valve open).
- done, output, 1, one-cycle pulse on expiry.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
- Reset state:
  - count = RESET_VALUE, state = IDLE, running = 0, done = 0.
  - Preset register = 0.
  - Reset overrides all other inputs in the same cycle.
- States: IDLE, RUN.
  - running = (state == RUN), registered.
- Load (any state):
  - preset is captured into the preset register, with each digit >9 clamped to 9.
  - count is set to the clamped value.
  - If the clamped value is 0: state = IDLE and done pulses the next cycle.
  - Otherwise: state = RUN.
- load and tick in the same cycle: load wins and the tick is dropped.
- RUN with tick:
  - BCD decrement, ripple borrow digit 0 upward.
  - A digit at 0 with borrow-in becomes 9 and borrows out; otherwise it decrements by 1.
  - Counting continues down to and including 0.
- Expiry: in RUN, tick arrives while count is 1 (i.e. the count would become 0).
  - Count takes 0.
  - done is asserted for exactly one cycle, in the cycle after the tick edge.
  - auto_reload = 0: state goes to IDLE and count holds 0.
  - auto_reload = 1: count is reloaded from the preset register on the next tick instead of decrementing. 0 is displayed for one tick period; state stays RUN.
- IDLE: tick is ignored and count holds.
- Wrap-around: count never underflows below 0; no 99→... wrap.
- auto_reload is sampled at expiry only. Changing it mid-run has no other effect.
- Latency:
  - count updates on the edge where tick or load is sampled high.
  - done/running are registered, so they lag that edge by 0 cycles relative to count (same edge).

Optional Feature:
- Macro: IRRIGATION_TIMER_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause = 1 in RUN: ticks are ignored, count holds, running stays 1.
  - load and reset still act normally.
- Undefined:
  - No pause port.
  - Behaviour is exactly as above.

Decomposition:
- Package irrigation_pkg:
  - state enum {IDLE, RUN}
  - BCD_W = 4, BCD_MAX = 4'd9
  - function bcd_clamp(digit)
- Sub-module bcd_down_digit, instantiated DIGITS times:
  - Inputs: clk, reset, load, load_digit, dec_en, borrow_in.
  - Outputs: digit, borrow_out, is_zero.
  - Purely per-digit; the top level holds the FSM and the preset register.

Test Plan:
- DIGITS=2; reset, then load preset=0x12, 12 ticks, auto_reload=0 → count 12,11,10,09…01,00. done pulses once on the 12th tick; running falls to 0 on the same edge; further ticks leave 00.
- Preset 0x10, one tick → count 09 (borrow across digits); running stays 1.
- auto_reload=1, preset 0x03, 8 ticks → count 02,01,00(done),03,02,01,00(done),03; running is 1 throughout.
- Load 0x3C (invalid LSD) → count 39. Load 0x00 → running 0, done pulses once.
- Mid-run at count 05: load 0x20 with tick in the same cycle → count 20 (tick dropped). Then assert reset with tick → count = RESET_VALUE, running 0, done 0.
- IRRIGATION_TIMER_PAUSE_EN defined: pause=1 for 5 ticks at count 07 → count holds 07, running stays 1. pause=0 and 1 tick → count 06.
